// File: rtl/pipes.sv
// Shared pipeline types: decoded control bundle, ALU function codes and immediate formats.
package pipes;

  typedef enum logic [3:0] {
    OP_NONE, ALU, ALUW, ALUI, ALUIW, LD, SD, BRANCH, LUI, AUIPC, JAL, JALR
  } op_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alufunc_t;

  typedef struct packed {
    op_t      op;
    alufunc_t alufunc;
    logic     regwrite;
  } contral_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV immediate generator, sign-extended from instr[31] to XLEN.
module imm_gen
  import pipes::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]            instr,
  input  imm_fmt_t               fmt,
  output logic signed [XLEN-1:0] imm
);

  logic signed [31:0] imm32;
  logic               unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/operand_stage.sv
// Decode-to-execute operand stage: operand/target generation, load-use hazard
// tracking and a valid/ready output register.
module operand_stage
  import pipes::*;
#(
  parameter int XLEN   = 64,
  parameter int LD_LAT = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  contral_t          in_ctl,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [4:0]        in_ra1,
  input  logic [4:0]        in_ra2,
  input  logic [4:0]        in_rd,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  output logic              out_valid,
  input  logic              out_ready,
  output contral_t          out_ctl,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_a,
  output logic [XLEN-1:0]   out_b,
  output logic [XLEN-1:0]   out_sdata,
  output logic [XLEN-1:0]   out_target,
  output logic [31:0]       stall_cnt
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [XLEN-1:0] ext_w(input logic [XLEN-1:0] v, input logic sgn);
    logic signed [31:0] lo_s;
    logic        [31:0] lo_u;
    lo_s = v[31:0];
    lo_u = v[31:0];
    if (sgn) return XLEN'(lo_s);
    return XLEN'(lo_u);
  endfunction

  imm_fmt_t               fmt;
  logic signed [XLEN-1:0] imm;
  logic                   use_rs1, use_rs2, hazard, xfer, fire, ld_fire;
  logic [XLEN-1:0]        a_p0, b_p0, sdata_p0, target_p0;

  logic                   vld_p1;
  contral_t               ctl_p1;
  logic [4:0]             rd_p1;
  logic [XLEN-1:0]        a_p1, b_p1, sdata_p1, target_p1;
  logic [LD_LAT-1:0]      pend_vld;
  logic [LD_LAT-1:0][4:0] pend_rd;
  logic [31:0]            stall_q;

  // ---- stage p0: immediate, operand mux, hazard ----
  always_comb begin
    case (in_ctl.op)
      SD:          fmt = IMM_S;
      BRANCH:      fmt = IMM_B;
      LUI, AUIPC:  fmt = IMM_U;
      JAL:         fmt = IMM_J;
      default:     fmt = IMM_I;
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .fmt   (fmt),
    .imm   (imm)
  );

  always_comb begin
    a_p0      = in_rs1;
    b_p0      = in_rs2;
    sdata_p0  = '0;
    target_p0 = '0;
    case (in_ctl.op)
      ALUW: begin
        // Word divides see only the low 32 bits, extended the way the divider expects.
        if (XLEN > 32 && in_ctl.alufunc inside {ALU_DIV, ALU_REM}) begin
          a_p0 = ext_w(in_rs1, 1'b1);
          b_p0 = ext_w(in_rs2, 1'b1);
        end else if (XLEN > 32 && in_ctl.alufunc inside {ALU_DIVU, ALU_REMU}) begin
          a_p0 = ext_w(in_rs1, 1'b0);
          b_p0 = ext_w(in_rs2, 1'b0);
        end
      end
      ALUI, ALUIW, LD: b_p0 = imm;
      SD: begin
        b_p0     = imm;
        sdata_p0 = in_rs2;
      end
      BRANCH: target_p0 = in_pc + imm;
      LUI: begin
        a_p0 = '0;
        b_p0 = imm;
      end
      AUIPC: begin
        a_p0 = in_pc;
        b_p0 = imm;
      end
      JAL: begin
        a_p0      = in_pc;
        b_p0      = XLEN'(4);
        target_p0 = in_pc + imm;
      end
      JALR: begin
        a_p0      = in_pc;
        b_p0      = XLEN'(4);
        target_p0 = in_rs1 + imm;
        target_p0[0] = 1'b0;
      end
      default: ;
    endcase
  end

  assign use_rs1 = in_ctl.op inside {ALU, ALUW, ALUI, ALUIW, LD, SD, BRANCH, JALR};
  assign use_rs2 = in_ctl.op inside {ALU, ALUW, SD, BRANCH};

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LD_LAT; i++) begin
      if (pend_vld[i] && use_rs1 && in_ra1 != 5'd0 && in_ra1 == pend_rd[i]) hazard = 1'b1;
      if (pend_vld[i] && use_rs2 && in_ra2 != 5'd0 && in_ra2 == pend_rd[i]) hazard = 1'b1;
    end
    if (vld_p1 && ctl_p1.op == LD) begin
      if (use_rs1 && in_ra1 != 5'd0 && in_ra1 == rd_p1) hazard = 1'b1;
      if (use_rs2 && in_ra2 != 5'd0 && in_ra2 == rd_p1) hazard = 1'b1;
    end
  end

  assign fire     = vld_p1 & out_ready;
  assign ld_fire  = fire & (ctl_p1.op == LD) & (rd_p1 != 5'd0);
  assign in_ready = (~vld_p1 | out_ready) & ~hazard & ~flush;
  assign xfer     = in_valid & in_ready;

  // ---- stage p1: output register, pending-load tracker, stall counter ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1    <= 1'b0;
      ctl_p1    <= '0;
      rd_p1     <= '0;
      a_p1      <= '0;
      b_p1      <= '0;
      sdata_p1  <= '0;
      target_p1 <= '0;
      pend_vld  <= '0;
      pend_rd   <= '0;
      stall_q   <= '0;
    end else begin
      if (flush)     vld_p1 <= 1'b0;
      else if (xfer) vld_p1 <= 1'b1;
      else if (fire) vld_p1 <= 1'b0;

      if (xfer) begin
        ctl_p1    <= in_ctl;
        rd_p1     <= in_rd;
        a_p1      <= a_p0;
        b_p1      <= b_p0;
        sdata_p1  <= sdata_p0;
        target_p1 <= target_p0;
      end

      // Flush does not touch the tracker: squashed or not, a fired load is in flight.
      pend_vld[0] <= ld_fire;
      pend_rd[0]  <= ld_fire ? rd_p1 : 5'd0;
      for (int i = 1; i < LD_LAT; i++) begin
        pend_vld[i] <= pend_vld[i-1];
        pend_rd[i]  <= pend_rd[i-1];
      end

      if (in_valid && hazard) stall_q <= sat_inc(stall_q);
    end
  end

  assign out_valid  = vld_p1;
  assign out_ctl    = ctl_p1;
  assign out_rd     = rd_p1;
  assign out_a      = a_p1;
  assign out_b      = b_p1;
  assign out_sdata  = sdata_p1;
  assign out_target = target_p1;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage (XLEN=64, LD_LAT=2): vector table plus load-use,
// backpressure/flush and mid-run reset sequences.
module tb_operand_stage;
  import pipes::*;

  logic        clk, resetn, flush, in_valid, in_ready, out_valid, out_ready;
  contral_t    in_ctl, out_ctl;
  logic [31:0] in_instr, stall_cnt;
  logic [63:0] in_pc, in_rs1, in_rs2, out_a, out_b, out_sdata, out_target;
  logic [4:0]  in_ra1, in_ra2, in_rd, out_rd;

  operand_stage #(.XLEN(64), .LD_LAT(2)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctl(in_ctl), .in_instr(in_instr),
    .in_pc(in_pc), .in_ra1(in_ra1), .in_ra2(in_ra2), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctl(out_ctl), .out_rd(out_rd),
    .out_a(out_a), .out_b(out_b), .out_sdata(out_sdata), .out_target(out_target),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    op_t         op;
    alufunc_t    fn;
    logic [31:0] instr;
    logic [63:0] pc, rs1, rs2;
    logic [63:0] a, b, sdata, target;
  } vec_t;

  vec_t vq[$];
  int   n_chk, n_fail, stalls;

  task automatic add(input string name, input op_t op, input alufunc_t fn,
                     input logic [31:0] instr, input logic [63:0] pc, rs1, rs2,
                     input logic [63:0] a, b, sdata, target);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.instr = instr; v.pc = pc;
    v.rs1 = rs1; v.rs2 = rs2; v.a = a; v.b = b; v.sdata = sdata; v.target = target;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input op_t op, input alufunc_t fn, input logic [4:0] rd, ra1, ra2,
                       input logic [31:0] instr, input logic [63:0] pc, rs1, rs2);
    in_ctl.op = op; in_ctl.alufunc = fn; in_ctl.regwrite = 1'b1;
    in_rd = rd; in_ra1 = ra1; in_ra2 = ra2;
    in_instr = instr; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    clk = 0; resetn = 0; flush = 0; in_valid = 0; out_ready = 1;
    drive(OP_NONE, ALU_ADD, 5'd0, 5'd0, 5'd0, 32'h0, 64'h0, 64'h0, 64'h0);

    add("addi",    ALUI,   ALU_ADD,  32'hFFF08293, 64'h0,    64'h7,    64'h0,
        64'h7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0);
    add("add",     ALU,    ALU_ADD,  32'h0,        64'h0,    64'h5,    64'h3,
        64'h5, 64'h3, 64'h0, 64'h0);
    add("divw",    ALUW,   ALU_DIV,  32'h0,        64'h0,    64'h1_8000_0000, 64'h2,
        64'hFFFF_FFFF_8000_0000, 64'h2, 64'h0, 64'h0);
    add("divuw",   ALUW,   ALU_DIVU, 32'h0,        64'h0,    64'h1_8000_0000, 64'h2,
        64'h0000_0000_8000_0000, 64'h2, 64'h0, 64'h0);
    add("addw",    ALUW,   ALU_ADD,  32'h0,        64'h0,    64'h1_8000_0000, 64'h2,
        64'h1_8000_0000, 64'h2, 64'h0, 64'h0);
    add("remuw",   ALUW,   ALU_REMU, 32'h0,        64'h0,    64'hFFFF_FFFF_FFFF_FFF0, 64'h1234_5678_8765_4321,
        64'h0000_0000_FFFF_FFF0, 64'h0000_0000_8765_4321, 64'h0, 64'h0);
    add("jalr",    JALR,   ALU_ADD,  32'h00400067, 64'h200,  64'h1001, 64'h0,
        64'h200, 64'h4, 64'h0, 64'h1004);
    add("beq",     BRANCH, ALU_SUB,  32'hFE000CE3, 64'h100,  64'h3,    64'h3,
        64'h3, 64'h3, 64'h0, 64'hF8);
    add("lui",     LUI,    ALU_ADD,  32'h12345037, 64'h0,    64'h99,   64'h0,
        64'h0, 64'h1234_5000, 64'h0, 64'h0);
    add("lui_neg", LUI,    ALU_ADD,  32'h80000037, 64'h0,    64'h0,    64'h0,
        64'h0, 64'hFFFF_FFFF_8000_0000, 64'h0, 64'h0);
    add("auipc",   AUIPC,  ALU_ADD,  32'h00001017, 64'h400,  64'h0,    64'h0,
        64'h400, 64'h1000, 64'h0, 64'h0);
    add("jal_pos", JAL,    ALU_ADD,  32'h0080006F, 64'h1000, 64'h0,    64'h0,
        64'h1000, 64'h4, 64'h0, 64'h1008);
    add("jal_neg", JAL,    ALU_ADD,  32'hFFDFF06F, 64'h1000, 64'h0,    64'h0,
        64'h1000, 64'h4, 64'h0, 64'hFFC);
    add("sd",      SD,     ALU_ADD,  32'h00003423, 64'h0,    64'h2000, 64'hDEAD,
        64'h2000, 64'h8, 64'hDEAD, 64'h0);
    add("sd_neg",  SD,     ALU_ADD,  32'hFE000FA3, 64'h0,    64'h2000, 64'hBEEF,
        64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hBEEF, 64'h0);
    add("ld",      LD,     ALU_ADD,  32'h01003183, 64'h0,    64'h100,  64'h0,
        64'h100, 64'h10, 64'h0, 64'h0);
    add("aluiw",   ALUIW,  ALU_ADD,  32'h80000013, 64'h0,    64'h1,    64'h0,
        64'h1, 64'hFFFF_FFFF_FFFF_F800, 64'h0, 64'h0);
    add("default", OP_NONE, ALU_ADD, 32'h0,        64'h0,    64'h1,    64'h2,
        64'h1, 64'h2, 64'h0, 64'h0);

    // Reset state
    #3;
    check("rst out_valid", 64'(out_valid), 64'h0);
    check("rst out_a", out_a, 64'h0);
    check("rst stall_cnt", 64'(stall_cnt), 64'h0);
    @(negedge clk);
    resetn = 1;
    #1;
    check("rst in_ready", 64'(in_ready), 64'h1);

    // Vector table
    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].op, vq[i].fn, 5'd0, 5'd0, 5'd0, vq[i].instr, vq[i].pc, vq[i].rs1, vq[i].rs2);
      in_valid = 1;
      #1;
      check({vq[i].name, " in_ready"}, 64'(in_ready), 64'h1);
      @(posedge clk);
      #1;
      check({vq[i].name, " out_valid"}, 64'(out_valid), 64'h1);
      check({vq[i].name, " out_a"}, out_a, vq[i].a);
      check({vq[i].name, " out_b"}, out_b, vq[i].b);
      check({vq[i].name, " out_sdata"}, out_sdata, vq[i].sdata);
      check({vq[i].name, " out_target"}, out_target, vq[i].target);
    end
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);

    // Load-use: LD x3 then ADD x4,x3,x2
    drive(LD, ALU_ADD, 5'd3, 5'd0, 5'd0, 32'h01003183, 64'h0, 64'h100, 64'h0);
    in_valid = 1;
    @(negedge clk);
    drive(ALU, ALU_ADD, 5'd4, 5'd3, 5'd2, 32'h0, 64'h0, 64'h55, 64'h66);
    #1;
    stalls = 0;
    while (!in_ready && stalls < 10) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check("load_use stall cycles", 64'(stalls), 64'd3);
    @(posedge clk);
    #1;
    check("load_use out_valid", 64'(out_valid), 64'h1);
    check("load_use out_a", out_a, 64'h55);
    check("load_use out_b", out_b, 64'h66);
    check("load_use out_rd", 64'(out_rd), 64'd4);
    check("load_use stall_cnt", 64'(stall_cnt), 64'd3);

    // Load to x0 never stalls
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    drive(LD, ALU_ADD, 5'd0, 5'd0, 5'd0, 32'h01003183, 64'h0, 64'h100, 64'h0);
    in_valid = 1;
    @(negedge clk);
    drive(ALU, ALU_ADD, 5'd4, 5'd0, 5'd0, 32'h0, 64'h0, 64'h77, 64'h1);
    #1;
    check("x0_load in_ready", 64'(in_ready), 64'h1);
    @(posedge clk);
    #1;
    check("x0_load out_a", out_a, 64'h77);
    check("x0_load stall_cnt", 64'(stall_cnt), 64'd3);

    // Backpressure for 5 cycles, flush in cycle 3
    @(negedge clk);
    drive(ALU, ALU_ADD, 5'd6, 5'd0, 5'd0, 32'h0, 64'h0, 64'h11, 64'h12);
    in_valid = 1;
    out_ready = 1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      out_ready = 0;
      if (k <= 3) begin
        drive(ALU, ALU_ADD, 5'd7, 5'd0, 5'd0, 32'h0, 64'h0, 64'h22, 64'h23);
        in_valid = 1;
      end else begin
        in_valid = 0;
      end
      flush = (k == 3);
      #1;
      if (k <= 3) begin
        check($sformatf("hold%0d in_ready", k), 64'(in_ready), 64'h0);
        check($sformatf("hold%0d out_valid", k), 64'(out_valid), 64'h1);
        check($sformatf("hold%0d out_a", k), out_a, 64'h11);
        check($sformatf("hold%0d out_b", k), out_b, 64'h12);
      end else begin
        check($sformatf("flushed%0d out_valid", k), 64'(out_valid), 64'h0);
      end
    end
    @(negedge clk);
    flush = 0;
    out_ready = 1;
    in_valid = 0;

    // Reset with a valid load in the output register and the tracker full
    @(negedge clk);
    drive(LD, ALU_ADD, 5'd7, 5'd0, 5'd0, 32'h01003183, 64'h0, 64'h70, 64'h0);
    in_valid = 1;
    @(negedge clk);
    drive(LD, ALU_ADD, 5'd8, 5'd0, 5'd0, 32'h01003183, 64'h0, 64'h80, 64'h0);
    @(negedge clk);
    drive(LD, ALU_ADD, 5'd9, 5'd0, 5'd0, 32'h01003183, 64'h0, 64'h99, 64'h0);
    @(negedge clk);
    in_valid = 0;
    out_ready = 0;
    #1;
    check("pre_rst out_valid", 64'(out_valid), 64'h1);
    check("pre_rst out_a", out_a, 64'h99);
    #1;
    resetn = 0;
    #1;
    check("async_rst out_valid", 64'(out_valid), 64'h0);
    check("async_rst out_a", out_a, 64'h0);
    check("async_rst out_b", out_b, 64'h0);
    check("async_rst out_rd", 64'(out_rd), 64'h0);
    check("async_rst out_ctl", 64'(out_ctl), 64'h0);
    check("async_rst stall_cnt", 64'(stall_cnt), 64'h0);
    @(negedge clk);
    resetn = 1;
    out_ready = 1;
    drive(ALU, ALU_ADD, 5'd4, 5'd7, 5'd8, 32'h0, 64'h0, 64'hAB, 64'hCD);
    in_valid = 1;
    #1;
    check("post_rst in_ready", 64'(in_ready), 64'h1);
    @(posedge clk);
    #1;
    check("post_rst out_valid", 64'(out_valid), 64'h1);
    check("post_rst out_a", out_a, 64'hAB);
    check("post_rst stall_cnt", 64'(stall_cnt), 64'h0);
    @(negedge clk);
    in_valid = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
# operand_stage

Registered decode-to-execute operand stage for the RV pipeline, parametrised in XLEN and load latency. It generates ALU operands and immediates for all RV formats (I/S/B/U/J), computes control-transfer targets, and applies W-op divide extension. It owns load-use hazard detection through a pending-load shift register, and registers results behind a valid/ready handshake. It sits between the register-file read in decode and the execute stage, and replaces the combinational operand/bubble logic there.

## Interface
- `XLEN`, 64: datapath width, 32 or 64.
- `LD_LAT`, 2: cycles after leaving this stage before a load result is forwardable.
- `clk`  in  1  clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `flush`  in  1  squash the output register.
- `in_valid`  in  1  decode has an instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `in_ctl`  in  contral_t  decoded control; uses `op`, `alufunc`, `regwrite`.
- `in_instr`  in  32  raw instruction.
- `in_pc`  in  XLEN  instruction PC.
- `in_ra1`, `in_ra2`, `in_rd`  in  5 each  source and destination indices.
- `in_rs1`, `in_rs2`  in  XLEN each  register-file read values.
- `out_valid`  out  1  registered result valid.
- `out_ready`  in  1  execute accepts.
- `out_ctl`  out  contral_t  registered control.
- `out_rd`  out  5  registered destination index.
- `out_a`, `out_b`  out  XLEN each  ALU operands.
- `out_sdata`  out  XLEN  store data.
- `out_target`  out  XLEN  branch/jump target.
- `stall_cnt`  out  32  saturating count of hazard-stall cycles.

## Operation
- Immediates are sign-extended from bit 31 to XLEN:
  - I: instr[31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
- Operand selection by `in_ctl.op`:
  - ALU: a=rs1, b=rs2.
  - ALUW: a=rs1, b=rs2. With DIV/REM, both are sign-extended from bit 31. With DIVU/REMU, both are zero-extended from bit 31. When XLEN=32, ALUW is treated as ALU.
  - ALUI, ALUIW, LD: a=rs1, b=I-imm.
  - SD: a=rs1, b=S-imm, sdata=rs2.
  - BRANCH: a=rs1, b=rs2, target=pc+B-imm.
  - LUI: a=0, b=U-imm.
  - AUIPC: a=pc, b=U-imm.
  - JAL: a=pc, b=4, target=pc+J-imm.
  - JALR: a=pc, b=4, target=(rs1+I-imm) with bit0 cleared.
  - default: a=rs1, b=rs2.
- Outputs not listed for an op are 0.
- Source use:
  - rs1 is used by ALU, ALUW, ALUI, ALUIW, LD, SD, BRANCH, JALR.
  - rs2 is used by ALU, ALUW, SD, BRANCH.
- Pending-load tracker: `pend[0..LD_LAT-1]`, each entry {valid, rd}.
  - Every cycle it shifts toward index LD_LAT-1, and the last entry drops.
  - Entry 0 loads {1, out_rd} when an LD with rd≠0 fires (out_valid & out_ready), else {0, x}.
- `hazard` is asserted when a used source index ≠0 matches the rd of any valid `pend` entry, or matches out_rd while the output register holds a valid LD.
- `in_ready = (!out_valid | out_ready) & !hazard & !flush`. A transfer in is `in_valid & in_ready`.
- `stall_cnt` increments each cycle with `in_valid & hazard`, saturating at 2^32-1.

## Timing
- Latency is 1 cycle: registered outputs appear on the cycle after acceptance.
- While `out_valid & !out_ready`, all out_* hold stable.
- `out_valid` next-state:
  - 0 if `flush`.
  - else 1 on an in-transfer.
  - else 0 if it fired.
  - else held.
- `flush` overrides a same-cycle in-transfer and a same-cycle out-fire; it does not clear `pend`, so in-flight loads stay tracked.
- Reset (asynchronous, may arrive at any cycle): out_valid=0, all out_* data=0, out_ctl='0, pend all invalid, stall_cnt=0. The first accept is possible on the first edge after release.
- If a hazard clears and `out_ready` is high in the same cycle, the accept happens that cycle. There is no extra bubble.

## Structure
- The `op_t`, `alufunc` enums and `contral_t` stay in `pipes`; add `imm_fmt_t` {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} there.
- Sub-module `imm_gen #(XLEN)`: combinational, taking instr and imm_fmt_t and producing the XLEN immediate. The operand mux, tracker and output register live in `operand_stage`.

## Test plan
- ADDI x5,x1,-1 (instr 0xFFF08293), rs1=7, XLEN=64, out_ready=1 -> next cycle out_a=7, out_b=0xFFFF_FFFF_FFFF_FFFF, out_valid=1.
- DIVW with rs1=0x1_8000_0000, rs2=0x2 -> out_a=0xFFFF_FFFF_8000_0000, out_b=2. The same operands with DIVUW -> out_a=0x0000_0000_8000_0000.
- LD x3 fires, then ADD x4,x3,x2 with LD_LAT=2 -> in_ready=0 for 3 cycles (output register, then pend[0], then pend[1]), accept on the 4th, stall_cnt=3. With rd=x0 -> no stall.
- JALR with rs1=0x1001, imm=4 -> out_target=0x1004, out_a=pc, out_b=4. BEQ at pc=0x100 with imm=-8 -> target=0xF8.
- out_ready=0 for 5 cycles while out_valid=1 -> outputs stable and in_ready=0. flush in cycle 3 -> out_valid=0 next cycle.
- Reset asserted while out_valid=1 and pend is full -> all outputs 0 immediately. After release, a dependent instruction is accepted with no stall.
